// File: rtl/pc_stack.sv
// pc_stack: program counter with a LIFO return stack for call/return and a tri-state address bus.
// Ports:
//   nCLK  - clock, all state changes on the falling edge
//   CLR   - asynchronous active-high reset
//   Cp/Lp/Cc/Rt - increment / jump / call / return requests (priority Rt > Cc > Lp > Cp)
//   Ep    - drives PC onto ABUS
//   DIN   - jump/call target
//   ABUS  - PC when Ep=1, high-Z otherwise
//   PC    - registered counter value
//   FULL/EMPTY - stack occupancy decodes
//   WRAP  - one-cycle flag after an increment from all-ones to zero
//   ERR   - sticky overflow/underflow flag
module pc_stack #(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VEC = '0
) (
    input  logic             nCLK,
    input  logic             CLR,
    input  logic             Cp,
    input  logic             Lp,
    input  logic             Cc,
    input  logic             Rt,
    input  logic             Ep,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] ABUS,
    output logic [WIDTH-1:0] PC,
    output logic             FULL,
    output logic             EMPTY,
    output logic             WRAP,
    output logic             ERR
);
    // Pointer counts 0..DEPTH, so it needs one more state than the entry count.
    localparam int PW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] pc_q, pc_d, top;
    logic [PW-1:0]    sp_q, sp_d;
    logic             wrap_q, wrap_d, err_q, err_d, push;
    logic [WIDTH-1:0] stk_q [DEPTH];
    assign PC    = pc_q;
    assign WRAP  = wrap_q;
    assign ERR   = err_q;
    assign FULL  = sp_q == PW'(DEPTH);
    assign EMPTY = sp_q == '0;
    assign ABUS  = Ep ? pc_q : 'z;
    // Entry just below the pointer; compare loop avoids index-width issues for any DEPTH.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++)
            if (sp_q == PW'(i + 1)) top = stk_q[i];
    end
    // Erroring Cc/Rt still win priority, so lower requests are dropped that cycle.
    always_comb begin
        pc_d   = pc_q;
        sp_d   = sp_q;
        wrap_d = 1'b0;
        err_d  = err_q;
        push   = 1'b0;
        if (Rt) begin
            if (EMPTY) err_d = 1'b1;
            else begin
                pc_d = top;
                sp_d = sp_q - PW'(1);
            end
        end else if (Cc) begin
            if (FULL) err_d = 1'b1;
            else begin
                push = 1'b1;
                pc_d = DIN;
                sp_d = sp_q + PW'(1);
            end
        end else if (Lp) begin
            pc_d = DIN;
        end else if (Cp) begin
            pc_d   = pc_q + WIDTH'(1);
            wrap_d = &pc_q;
        end
    end
    always_ff @(negedge nCLK or posedge CLR) begin
        if (CLR) begin
            pc_q   <= RST_VEC;
            sp_q   <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            sp_q   <= sp_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end
    // Storage is not reset; a zero pointer makes stale entries unreachable.
    always_ff @(negedge nCLK) begin
        for (int i = 0; i < DEPTH; i++)
            if (push && !CLR && sp_q == PW'(i)) stk_q[i] <= pc_q + WIDTH'(1);
    end
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed and random checks of pc_stack against a queue-based reference model.
module tb_pc_stack;
    logic       nclk = 1'b1;
    logic       clr = 1'b1;
    logic       cp = 0, lp = 0, cc = 0, rt = 0, ep = 0;
    logic [3:0] din = '0;
    logic [3:0] abus, pc, abus1, pc1;
    logic       full, empty, wrap, err, full1, empty1, wrap1, err1;
    int         n_chk = 0, n_err = 0;

    logic [3:0] m_pc;
    logic [3:0] m_stk[$];
    logic       m_err, m_wrap;

    pc_stack #(.WIDTH(4), .DEPTH(2), .RST_VEC(4'd0)) u0 (
        .nCLK(nclk), .CLR(clr), .Cp(cp), .Lp(lp), .Cc(cc), .Rt(rt), .Ep(ep), .DIN(din),
        .ABUS(abus), .PC(pc), .FULL(full), .EMPTY(empty), .WRAP(wrap), .ERR(err));

    pc_stack #(.WIDTH(4), .DEPTH(2), .RST_VEC(4'd10)) u1 (
        .nCLK(nclk), .CLR(clr), .Cp(cp), .Lp(lp), .Cc(cc), .Rt(rt), .Ep(ep), .DIN(din),
        .ABUS(abus1), .PC(pc1), .FULL(full1), .EMPTY(empty1), .WRAP(wrap1), .ERR(err1));

    always #5 nclk = ~nclk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 4'd0;
        m_stk.delete();
        m_err = 1'b0;
        m_wrap = 1'b0;
    endtask

    task automatic model_step();
        m_wrap = 1'b0;
        if (rt) begin
            if (m_stk.size() == 0) m_err = 1'b1;
            else m_pc = m_stk.pop_back();
        end else if (cc) begin
            if (m_stk.size() == 2) m_err = 1'b1;
            else begin
                m_stk.push_back(m_pc + 4'd1);
                m_pc = din;
            end
        end else if (lp) m_pc = din;
        else if (cp) begin
            m_wrap = (m_pc == 4'd15);
            m_pc = m_pc + 4'd1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".full"}, {3'b0, full}, {3'b0, m_stk.size() == 2});
        chk({tag, ".empty"}, {3'b0, empty}, {3'b0, m_stk.size() == 0});
        chk({tag, ".wrap"}, {3'b0, wrap}, {3'b0, m_wrap});
        chk({tag, ".err"}, {3'b0, err}, {3'b0, m_err});
        chk({tag, ".abus"}, abus, ep ? m_pc : 4'bzzzz);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(negedge nclk);
        #1;
        check_all(tag);
    endtask

    task automatic set(input logic r, input logic c, input logic l, input logic p, input logic [3:0] d);
        rt = r; cc = c; lp = l; cp = p; din = d;
    endtask

    // Asynchronous reset pulse between edges, checked before the next edge.
    task automatic do_reset(input string tag);
        clr = 1'b1;
        #2;
        m_reset();
        check_all(tag);
        chk({tag, ".pc_rstvec"}, pc1, 4'd10);
        clr = 1'b0;
    endtask

    initial begin
        m_reset();
        @(negedge nclk);
        #1;
        check_all("reset");
        chk("reset.pc_rstvec", pc1, 4'd10);
        clr = 1'b0;

        set(0, 0, 0, 1, 4'd0);
        for (int i = 0; i < 16; i++) tick("count");
        chk("count.wrapped_pc", pc, 4'd0);
        chk("count.wrap_hi", {3'b0, wrap}, 4'd1);
        set(0, 0, 0, 0, 4'd0);
        tick("count.hold");

        set(0, 0, 1, 0, 4'd3); tick("call.load3");
        set(0, 1, 0, 0, 4'd9); tick("call.9");
        set(0, 1, 0, 0, 4'd12); tick("call.12");
        chk("call.full", {3'b0, full}, 4'd1);
        set(1, 0, 0, 0, 4'd0); tick("ret.10");
        chk("ret.pc10", pc, 4'd10);
        tick("ret.4");
        chk("ret.pc4", pc, 4'd4);
        chk("ret.empty", {3'b0, empty}, 4'd1);

        set(0, 1, 0, 0, 4'd9); tick("ovf.fill1");
        set(0, 1, 0, 0, 4'd12); tick("ovf.fill2");
        set(0, 1, 0, 1, 4'd5); tick("ovf.call");
        chk("ovf.pc12", pc, 4'd12);
        chk("ovf.err", {3'b0, err}, 4'd1);
        set(0, 0, 0, 1, 4'd0);
        for (int i = 0; i < 5; i++) tick("ovf.sticky");
        chk("ovf.err_sticky", {3'b0, err}, 4'd1);
        do_reset("ovf.clr");

        set(0, 0, 1, 0, 4'd7); tick("unf.load7");
        set(1, 0, 1, 0, 4'd2); tick("unf.ret");
        chk("unf.pc7", pc, 4'd7);
        chk("unf.err", {3'b0, err}, 4'd1);
        do_reset("unf.clr");

        set(0, 0, 1, 1, 4'd6); tick("prio.lp_cp");
        chk("prio.pc6", pc, 4'd6);
        set(0, 0, 1, 0, 4'd7); tick("prio.load7");
        set(0, 1, 0, 0, 4'd1); tick("prio.push8");
        set(1, 1, 0, 0, 4'd3); tick("prio.rt_cc");
        chk("prio.pc8", pc, 4'd8);
        chk("prio.empty", {3'b0, empty}, 4'd1);

        set(1, 0, 0, 0, 4'd0); tick("aclr.underflow");
        set(0, 1, 0, 0, 4'd3); tick("aclr.call");
        ep = 1'b1;
        #1;
        check_all("aclr.ep");
        do_reset("aclr");

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) do_reset("rand.clr");
            set($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1, 4'($urandom));
            ep = 1'($urandom);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
